light_map_tx: RTL and testbench

//  Consumer end of the zone-filter output interface. Captures per-zone backlight

---
 rtl/light_map_tx_pkg.sv | 10 +
 rtl/light_map_tx_if.sv | 26 ++
 rtl/light_map_tx_ram.sv | 21 ++
 rtl/light_map_tx.sv | 119 +++++++++++
 tb/tb_light_map_tx.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/light_map_tx_pkg.sv
// light_map_tx_pkg: screen geometry, light word format and transmit FSM states
package light_map_tx_pkg;
  localparam int ZONE_COLS    = 24;
  localparam int ZONE_ROWS    = 15;
  localparam int SCREEN_ZONES = ZONE_COLS * ZONE_ROWS;
  localparam int LIGHT_W      = 16;
  localparam int LIGHT_IDX_W  = 9;
  localparam int LED_CLK_DIV  = 4;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;
endpackage

// File: rtl/light_map_tx_if.sv
// light_map_tx_if: zone-filter write port plus MiniLED driver serial link and status
interface light_map_tx_if
  import light_map_tx_pkg::*;
#(
  parameter int DATA_W = LIGHT_W,
  parameter int IDX_W  = LIGHT_IDX_W
);
  logic [DATA_W-1:0] light;
  logic [IDX_W-1:0]  light_index;
  logic              get_map;
  logic              filter_end;
  logic              led_sdi;
  logic              led_sclk;
  logic              led_le;
  logic              busy;
  logic              tx_done;
  logic              overrun;
  modport master (
    output light, light_index, get_map, filter_end,
    input  led_sdi, led_sclk, led_le, busy, tx_done, overrun
  );
  modport slave (
    input  light, light_index, get_map, filter_end,
    output led_sdi, led_sclk, led_le, busy, tx_done, overrun
  );
endinterface

// File: rtl/light_map_tx_ram.sv
// light_map_ram: two-bank simple dual-port light map, one write port and one registered read port
module light_map_ram #(
  parameter int ZONES  = 360,
  parameter int DATA_W = 16,
  parameter int ZW     = 9
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ZW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ZW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2][ZONES];
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
    rd_data <= mem[rd_bank][rd_idx];
  end
endmodule

// File: rtl/light_map_tx.sv
// light_map_tx: ping-pong light map capture and MSB-first serial shift-out to the MiniLED driver chain
module light_map_tx
  import light_map_tx_pkg::*;
#(
  parameter int ZONES   = SCREEN_ZONES,
  parameter int DATA_W  = LIGHT_W,
  parameter int IDX_W   = LIGHT_IDX_W,
  parameter int CLK_DIV = LED_CLK_DIV
) (
  input logic           sys_clk,
  input logic           sys_rst,
  light_map_tx_if.slave bus
);
  localparam int ZW = $clog2(ZONES);
  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(2 * CLK_DIV);
  state_t            state, nstate;
  logic              wr_bank, n_wr_bank, rd_bank, n_rd_bank;
  logic [ZW-1:0]     zone, n_zone, rd_idx;
  logic [BW-1:0]     bitn, n_bitn;
  logic [DW-1:0]     div, n_div;
  logic [DATA_W-1:0] shreg, n_shreg, rd_data;
  logic              sdi, sclk, le, busy, tx_done, overrun;
  logic              wr_en, bit_end, word_end, last_zone;
  assign wr_en     = bus.get_map && bus.light_index < IDX_W'(ZONES);
  assign bit_end   = div == DW'(2 * CLK_DIV - 1);
  assign word_end  = bitn == BW'(DATA_W - 1);
  assign last_zone = zone == ZW'(ZONES - 1);
  // prefetch the next zone during the last bit so words follow back to back
  assign rd_idx = (state == SHIFT && word_end && !last_zone) ? zone + 1'b1 : zone;
  light_map_ram #(.ZONES(ZONES), .DATA_W(DATA_W), .ZW(ZW)) ram (
    .sys_clk (sys_clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_idx  (bus.light_index[ZW-1:0]),
    .wr_data (bus.light),
    .rd_bank (rd_bank),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );
  always_comb begin
    nstate    = state;
    n_wr_bank = wr_bank;
    n_rd_bank = rd_bank;
    n_zone    = zone;
    n_bitn    = bitn;
    n_div     = bit_end ? '0 : div + 1'b1;
    n_shreg   = shreg;
    case (state)
      IDLE: begin
        n_div = '0;
        if (bus.filter_end) begin
          nstate    = LOAD;
          n_rd_bank = wr_bank;
          n_wr_bank = ~wr_bank;
          n_zone    = '0;
        end
      end
      LOAD: if (div != '0) begin
        nstate  = SHIFT;
        n_div   = '0;
        n_bitn  = '0;
        n_shreg = rd_data;
      end
      SHIFT: if (bit_end) begin
        if (!word_end) begin
          n_bitn  = bitn + 1'b1;
          n_shreg = shreg << 1;
        end else if (last_zone) nstate = LATCH;
        else begin
          n_bitn  = '0;
          n_zone  = zone + 1'b1;
          n_shreg = rd_data;
        end
      end
      LATCH: if (bit_end) nstate = DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      zone    <= '0;
      bitn    <= '0;
      div     <= '0;
      shreg   <= '0;
      sdi     <= 1'b0;
      sclk    <= 1'b0;
      le      <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= nstate;
      wr_bank <= n_wr_bank;
      rd_bank <= n_rd_bank;
      zone    <= n_zone;
      bitn    <= n_bitn;
      div     <= n_div;
      shreg   <= n_shreg;
      sdi     <= nstate == SHIFT && n_shreg[DATA_W-1];
      sclk    <= nstate == SHIFT && n_div >= DW'(CLK_DIV);
      le      <= nstate == LATCH;
      busy    <= nstate != IDLE;
      tx_done <= nstate == DONE;
      overrun <= bus.filter_end && state != IDLE;
    end
  end
  assign bus.led_sdi  = sdi;
  assign bus.led_sclk = sclk;
  assign bus.led_le   = le;
  assign bus.busy     = busy;
  assign bus.tx_done  = tx_done;
  assign bus.overrun  = overrun;
endmodule

// File: tb/tb_light_map_tx.sv
// tb_light_map_tx: scoreboard bench for a 4-zone instance and a full-size default instance
module tb_light_map_tx;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;
  light_map_tx_if #(.DATA_W(16), .IDX_W(9)) s ();
  light_map_tx_if #(.DATA_W(16), .IDX_W(9)) b ();
  light_map_tx #(.ZONES(4), .DATA_W(16), .IDX_W(9), .CLK_DIV(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(s.slave));
  light_map_tx dut_big (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b.slave));
  int total = 0, bad = 0;
  logic [15:0] exp_q[$], exp_big[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask
  logic ps = 0, pb = 0;
  logic [15:0] w = '0;
  int nb = 0, rises = 0, le_run = 0, le_last = 0, bcnt = 0, done_cnt = 0, ovr_cnt = 0, le_total = 0;
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      ps = 0; pb = 0; nb = 0; rises = 0; le_run = 0; bcnt = 0;
    end else begin
      if (s.led_sclk && !ps) begin
        w = {w[14:0], s.led_sdi};
        nb++;
        rises++;
        if (nb == 16) begin
          nb = 0;
          if (exp_q.size() != 0) chk("small_word", w, exp_q.pop_front());
          else begin
            total++; bad++;
            $display("FAIL small_word: got 0x%h, queue empty", w);
          end
        end
      end
      ps = s.led_sclk;
      if (s.led_le) begin le_run++; le_total++; end
      else if (le_run != 0) begin le_last = le_run; le_run = 0; end
      if (s.busy) bcnt++;
      else if (pb) begin chk("small_busy_cycles", bcnt, 263); bcnt = 0; end
      pb = s.busy;
      if (s.tx_done) begin
        chk("small_le_cycles", le_last, 4);
        chk("small_sclk_rises", rises, 64);
        chk("small_words_left", exp_q.size(), 0);
        rises = 0;
        done_cnt++;
      end
      if (s.overrun) ovr_cnt++;
    end
  end
  logic bps = 0, bpb = 0;
  logic [15:0] bw = '0;
  int bnb = 0, brises = 0, ble_run = 0, ble_last = 0, bbcnt = 0, bdone = 0;
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      bps = 0; bpb = 0; bnb = 0; brises = 0; ble_run = 0; bbcnt = 0;
    end else begin
      if (b.led_sclk && !bps) begin
        bw = {bw[14:0], b.led_sdi};
        bnb++;
        brises++;
        if (bnb == 16) begin
          bnb = 0;
          if (exp_big.size() != 0) chk("big_word", bw, exp_big.pop_front());
          else begin
            total++; bad++;
            $display("FAIL big_word: got 0x%h, queue empty", bw);
          end
        end
      end
      bps = b.led_sclk;
      if (b.led_le) ble_run++;
      else if (ble_run != 0) begin ble_last = ble_run; ble_run = 0; end
      if (b.busy) bbcnt++;
      else if (bpb) begin chk("big_busy_cycles", bbcnt, 46091); bbcnt = 0; end
      bpb = b.busy;
      if (b.tx_done) begin
        chk("big_le_cycles", ble_last, 8);
        chk("big_sclk_rises", brises, 5760);
        chk("big_words_left", exp_big.size(), 0);
        brises = 0;
        bdone++;
      end
    end
  end
  task automatic wr_s(input int idx, input logic [15:0] v);
    s.get_map = 1'b1; s.light_index = 9'(idx); s.light = v;
    @(negedge sys_clk);
    s.get_map = 1'b0;
  endtask
  task automatic end_s(input logic [15:0] w0, w1, w2, w3, input bit push);
    if (push) begin exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3); end
    s.filter_end = 1'b1;
    @(negedge sys_clk);
    s.filter_end = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int start = done_cnt;
    for (int i = 0; i < 1000 && done_cnt == start; i++) @(negedge sys_clk);
    if (done_cnt == start) begin
      total++; bad++;
      $display("FAIL %s: no tx_done within 1000 cycles", name);
    end
    repeat (3) @(negedge sys_clk);
  endtask
  initial begin
    int le0, d0;
    s.light = '0; s.light_index = '0; s.get_map = 0; s.filter_end = 0;
    b.light = '0; b.light_index = '0; b.get_map = 0; b.filter_end = 0;
    repeat (3) @(negedge sys_clk);
    chk("reset_outs", {s.led_sdi, s.led_sclk, s.led_le, s.busy, s.tx_done, s.overrun}, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    wr_s(0, 16'h8001); wr_s(1, 16'h0000); wr_s(2, 16'hFFFF); wr_s(3, 16'h1234);
    end_s(16'h8001, 16'h0000, 16'hFFFF, 16'h1234, 1);
    repeat (20) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) wr_s(i, 16'hAAAA);
    end_s(0, 0, 0, 0, 0);
    wait_done("frame_a_done");
    chk("overrun_count", ovr_cnt, 1);
    end_s(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 1);
    wait_done("frame_b_done");
    wr_s(4, 16'hDEAD);
    end_s(16'h8001, 16'h0000, 16'hFFFF, 16'h1234, 1);
    wait_done("out_of_range_done");
    exp_q.push_back(16'hAAAA); exp_q.push_back(16'hAAAA); exp_q.push_back(16'hAAAA); exp_q.push_back(16'h5555);
    s.get_map = 1'b1; s.light_index = 9'd3; s.light = 16'h5555; s.filter_end = 1'b1;
    @(negedge sys_clk);
    s.get_map = 1'b0; s.filter_end = 1'b0;
    wait_done("same_cycle_done");
    le0 = le_total;
    d0 = done_cnt;
    end_s(0, 0, 0, 0, 0);
    repeat (30) @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    #1 chk("abort_outs", {s.led_sdi, s.led_sclk, s.led_le, s.busy, s.tx_done}, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("abort_no_le", le_total, le0);
    chk("abort_no_done", done_cnt, d0);
    wr_s(0, 16'h0F0F); wr_s(1, 16'hF0F0); wr_s(2, 16'h00FF); wr_s(3, 16'hFF00);
    end_s(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 1);
    wait_done("after_reset_done");
    for (int i = 0; i < 360; i++) begin
      b.get_map = 1'b1; b.light_index = 9'(i); b.light = 16'(i);
      @(negedge sys_clk);
    end
    b.get_map = 1'b0;
    for (int i = 0; i < 360; i++) exp_big.push_back(16'(i));
    b.filter_end = 1'b1;
    @(negedge sys_clk);
    b.filter_end = 1'b0;
    for (int i = 0; i < 50000 && bdone == 0; i++) @(negedge sys_clk);
    if (bdone == 0) begin
      total++; bad++;
      $display("FAIL big_done: no tx_done within 50000 cycles");
    end
    repeat (3) @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
